// File: rtl/div_if.sv
// div_if: the handshake and data bundle between the control unit and the
// multicycle divider.
//   DivCtrl  start pulse (control unit -> divider)
//   A, B     dividend / divisor operands (rs, rt)
//   HIDiv    remainder result, feeds the HI source mux
//   LODiv    quotient result, feeds the LO source mux
//   DivZero  one-cycle flag, the divisor was zero
//   DivStop  one-cycle flag, HIDiv/LODiv hold a new result
// Modports: master = control-unit side, slave = divider side.
interface div_if;
  logic        DivCtrl;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HIDiv;
  logic [31:0] LODiv;
  logic        DivZero;
  logic        DivStop;

  modport master (
    output DivCtrl, A, B,
    input  HIDiv, LODiv, DivZero, DivStop
  );

  modport slave (
    input  DivCtrl, A, B,
    output HIDiv, LODiv, DivZero, DivStop
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: multicycle 32-bit integer divider for the DIV instruction.
// Restoring shift-subtract, one quotient bit per clock (32 iterations),
// followed by a sign-fix/write state and a one-cycle DivStop pulse.
// A zero divisor skips the loop and produces a one-cycle DivZero pulse,
// leaving HIDiv/LODiv untouched.
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high; aborts any divide in progress
//   bus    div_if.slave: DivCtrl/A/B in, HIDiv/LODiv/DivZero/DivStop out
//
// Build option: define DIV_SIGNED_EN for signed DIV semantics (quotient
// truncates toward zero, remainder takes the dividend's sign). Without it
// the unit performs unsigned DIVU with identical cycle timing.
module div_unit (
  input  logic  clk,
  input  logic  reset,
  div_if.slave  bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd1;
  localparam logic [2:0] S_FIX  = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ZERO = 3'd4;

  logic [2:0]  state;
  logic [4:0]  cnt;
  logic [31:0] q;
  logic [31:0] dvs;
  // The partial remainder is always below the divisor after each step, so
  // its top bit is only needed transiently in the shifted value below.
  logic [31:0] rem;

`ifdef DIV_SIGNED_EN
  logic sign_q;
  logic sign_r;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return 32'd0 - v;
  endfunction

  // -2^31 maps to 0x80000000, which is exactly its unsigned magnitude.
  function automatic logic [31:0] mag32(input logic signed [31:0] v);
    return v[31] ? neg32(v) : v;
  endfunction
`endif

  logic [32:0] rem_sh;
  logic        ge;
  logic [32:0] rem_nxt;

  always_comb begin
    rem_sh  = {rem, q[31]};
    ge      = (rem_sh >= {1'b0, dvs});
    rem_nxt = ge ? (rem_sh - {1'b0, dvs}) : rem_sh;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      q           <= '0;
      dvs         <= '0;
      rem         <= '0;
`ifdef DIV_SIGNED_EN
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
`endif
      bus.HIDiv   <= '0;
      bus.LODiv   <= '0;
      bus.DivZero <= 1'b0;
      bus.DivStop <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.DivCtrl) begin
            if (bus.B == 32'd0) begin
              state <= S_ZERO;
            end else begin
`ifdef DIV_SIGNED_EN
              q      <= mag32(bus.A);
              dvs    <= mag32(bus.B);
              sign_q <= bus.A[31] ^ bus.B[31];
              sign_r <= bus.A[31];
`else
              q      <= bus.A;
              dvs    <= bus.B;
`endif
              rem    <= '0;
              cnt    <= '0;
              state  <= S_RUN;
            end
          end
        end

        S_RUN: begin
          rem <= rem_nxt[31:0];
          q   <= {q[30:0], ge};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state <= S_FIX;
          end
        end

        S_FIX: begin
`ifdef DIV_SIGNED_EN
          bus.LODiv <= sign_q ? neg32(q)   : q;
          bus.HIDiv <= sign_r ? neg32(rem) : rem;
`else
          bus.LODiv <= q;
          bus.HIDiv <= rem;
`endif
          bus.DivStop <= 1'b1;
          state       <= S_DONE;
        end

        S_DONE: begin
          bus.DivStop <= 1'b0;
          state       <= S_IDLE;
        end

        // Two cycles here: the first raises DivZero, the second drops it,
        // so the flag is high for the cycle after the entry edge.
        S_ZERO: begin
          if (!bus.DivZero) begin
            bus.DivZero <= 1'b1;
          end else begin
            bus.DivZero <= 1'b0;
            state       <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic clk;
  logic reset;

  div_if bus ();

  div_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  int n_chk;
  int n_pass;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference model: plain language arithmetic on the operand values.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] qq;
    logic [31:0] rr;
`ifdef DIV_SIGNED_EN
    longint sa;
    longint sb;
    longint sq;
    longint sr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sq = sa / sb;
    sr = sa % sb;
    qq = sq[31:0];
    rr = sr[31:0];
`else
    qq = a / b;
    rr = a % b;
`endif
    return {rr, qq};
  endfunction

  // Issue a start, then watch 40 cycles. rp>0 re-pulses DivCtrl with 9/3
  // just before edge rp (counted from the start edge).
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int rp,
                         output int stop_cyc, output int zero_cyc,
                         output int stop_cnt, output int zero_cnt, output int both_cnt);
    stop_cyc = -1; zero_cyc = -1; stop_cnt = 0; zero_cnt = 0; both_cnt = 0;
    bus.DivCtrl = 1'b1;
    bus.A = a;
    bus.B = b;
    @(posedge clk);
    #1;
    bus.DivCtrl = 1'b0;
    bus.A = $urandom;
    bus.B = $urandom;
    for (int k = 1; k <= 40; k++) begin
      if (k == rp) begin
        bus.DivCtrl = 1'b1;
        bus.A = 32'd9;
        bus.B = 32'd3;
      end
      @(posedge clk);
      #1;
      bus.DivCtrl = 1'b0;
      if (bus.DivStop) begin
        stop_cnt++;
        if (stop_cyc < 0) stop_cyc = k;
      end
      if (bus.DivZero) begin
        zero_cnt++;
        if (zero_cyc < 0) zero_cyc = k;
      end
      if (bus.DivStop && bus.DivZero) both_cnt++;
    end
  endtask

  task automatic check_ok(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lo, input logic [31:0] hi, input int rp);
    int sc, zc, sn, zn, bn;
    run_div(a, b, rp, sc, zc, sn, zn, bn);
    chk({tag, "_stopcyc"}, sc, 33);
    chk({tag, "_stopcnt"}, sn, 1);
    chk({tag, "_zerocnt"}, zn, 0);
    chk({tag, "_both"}, bn, 0);
    chk({tag, "_lo"}, bus.LODiv, lo);
    chk({tag, "_hi"}, bus.HIDiv, hi);
  endtask

  vec_t tbl[10];

  initial begin
    int sc, zc, sn, zn, bn;
    logic [31:0] ra, rb;
    logic [63:0] m;

    n_chk = 0;
    n_pass = 0;

`ifdef DIV_SIGNED_EN
    tbl[0] = '{32'd100,      32'd7,        32'd14,       32'd2};
    tbl[1] = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
    tbl[2] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0};
    tbl[3] = '{32'd9,        32'd3,        32'd3,        32'd0};
    tbl[4] = '{32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE};
    tbl[5] = '{32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2};
    tbl[6] = '{32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0};
    tbl[7] = '{32'd7,        32'd100,      32'd0,        32'd7};
    tbl[8] = '{32'h80000000, 32'd1,        32'h80000000, 32'd0};
    tbl[9] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0};
`else
    tbl[0] = '{32'd100,      32'd7,        32'd14,       32'd2};
    tbl[1] = '{32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 32'd1};
    tbl[2] = '{32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
    tbl[3] = '{32'd9,        32'd3,        32'd3,        32'd0};
    tbl[4] = '{32'hFFFFFF9C, 32'd7,        32'h24924916, 32'd2};
    tbl[5] = '{32'd100,      32'hFFFFFFF9, 32'd0,        32'd100};
    tbl[6] = '{32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0};
    tbl[7] = '{32'd7,        32'd100,      32'd0,        32'd7};
    tbl[8] = '{32'h80000000, 32'd1,        32'h80000000, 32'd0};
    tbl[9] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0};
`endif

    // Reset state
    reset = 1'b1;
    bus.DivCtrl = 1'b0;
    bus.A = 32'd0;
    bus.B = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", bus.HIDiv, 32'd0);
    chk("rst_lo", bus.LODiv, 32'd0);
    chk("rst_zero", {31'd0, bus.DivZero}, 32'd0);
    chk("rst_stop", {31'd0, bus.DivStop}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      check_ok($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].lo, tbl[i].hi, 0);
    end

    // Zero divisor after a known 100/7 result
    check_ok("pre_zero", 32'd100, 32'd7, 32'd14, 32'd2, 0);
    run_div(32'd5, 32'd0, 0, sc, zc, sn, zn, bn);
    chk("zero_cyc", zc, 1);
    chk("zero_cnt", zn, 1);
    chk("zero_stopcnt", sn, 0);
    chk("zero_lo", bus.LODiv, 32'd14);
    chk("zero_hi", bus.HIDiv, 32'd2);

    // DivCtrl re-pulse mid-operation is ignored
    check_ok("repulse", 32'd100, 32'd7, 32'd14, 32'd2, 10);

    // Reset mid-operation aborts, then a fresh divide completes
    bus.DivCtrl = 1'b1;
    bus.A = 32'd100;
    bus.B = 32'd7;
    @(posedge clk);
    #1;
    bus.DivCtrl = 1'b0;
    sn = 0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      if (bus.DivStop) sn++;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_stopcnt", sn, 0);
    chk("abort_hi", bus.HIDiv, 32'd0);
    chk("abort_lo", bus.LODiv, 32'd0);
    chk("abort_stop", {31'd0, bus.DivStop}, 32'd0);
    chk("abort_zero", {31'd0, bus.DivZero}, 32'd0);
    check_ok("after_abort", 32'd9, 32'd3, 32'd3, 32'd0, 0);

    // Start on the same edge as reset: reset wins
    reset = 1'b1;
    bus.DivCtrl = 1'b1;
    bus.A = 32'd50;
    bus.B = 32'd5;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.DivCtrl = 1'b0;
    sn = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.DivStop) sn++;
    end
    chk("rst_start_stopcnt", sn, 0);
    chk("rst_start_lo", bus.LODiv, 32'd0);

    // Randomized operands against the reference model
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 0) rb = $urandom_range(1, 20);
      if (i % 6 == 0) rb = 32'd0 - rb;
      if (rb == 32'd0) rb = 32'd1;
      m = model(ra, rb);
      check_ok($sformatf("rnd%0d", i), ra, rb, m[31:0], m[63:32], 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
